// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the 8-bit encryption round sequencer.
//   DATA_W / HALF_W : block width and Feistel half width
//   enc_state_e     : sequencer states
//   rotl8 / rotr8   : byte rotations used by the key schedule
// ---------------------------------------------------------------------------
package enc_pkg;

    localparam int DATA_W = 8;
    localparam int HALF_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_e;

    function automatic logic [DATA_W-1:0] rotl8(input logic [DATA_W-1:0] x,
                                                input logic [2:0]        n);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = x[3'(i - int'(n))];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] rotr8(input logic [DATA_W-1:0] x,
                                                input logic [2:0]        n);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = x[3'(i + int'(n))];
        end
        return r;
    endfunction

endpackage

// File: rtl/enc_round.sv
// ---------------------------------------------------------------------------
// enc_round
// One combinational Feistel round: expansion, key XOR, carry-select add,
// then the half update (swapped for inner rounds, unswapped for the last).
//   state_i : current block {H, L}
//   key_i   : round key
//   last_i  : high for the final round (no swap)
//   state_o : block after this round
// ---------------------------------------------------------------------------
module enc_round
    import enc_pkg::*;
(
    input  logic [DATA_W-1:0] state_i,
    input  logic [DATA_W-1:0] key_i,
    input  logic              last_i,
    output logic [DATA_W-1:0] state_o
);

    logic [HALF_W-1:0] l_half;
    logic [HALF_W-1:0] h_half;
    logic [DATA_W-1:0] exp_val;
    logic [DATA_W-1:0] x_val;
    logic [HALF_W-1:0] f_val;
    logic [HALF_W-1:0] h_mix;

    assign l_half  = state_i[HALF_W-1:0];
    assign h_half  = state_i[DATA_W-1:HALF_W];
    assign exp_val = {l_half[3], l_half[0], l_half[1], l_half[2],
                      l_half[1], l_half[3], l_half[2], l_half[0]};
    assign x_val   = exp_val ^ key_i;
    // Key bit 0 selects the carry-in: clear bit adds one.
    assign f_val   = x_val[7:4] + x_val[3:0] + {3'b000, ~key_i[0]};
    assign h_mix   = h_half ^ f_val;
    assign state_o = last_i ? {h_mix, l_half} : {l_half, h_mix};

endmodule

// File: rtl/enc_round_ctrl.sv
// ---------------------------------------------------------------------------
// enc_round_ctrl
// Multi-round Feistel sequencer around a single shared enc_round datapath.
// Accepts byte + key + mode, runs ROUNDS rounds with an on-the-fly key
// schedule, and presents the result on an output handshake.
//   clk_i, rst_ni           : clock, async active-low reset
//   abort_i                 : synchronous flush to IDLE
//   in_valid_i / in_ready_o : input handshake (ready only in IDLE)
//   data_in_i, key_in_i     : block and user key
//   decrypt_i               : 0 encrypt, 1 decrypt
//   out_valid_o/out_ready_i : output handshake (valid only in DONE)
//   data_out_o              : result, held until the next result
//   busy_o                  : high while rounds run
//   round_idx_o             : round applied at the next edge, 0 outside RUN
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | one round per edge, round_idx counts 0..ROUNDS-1
// DONE  | result presented, waiting for out_ready
// ---------------------------------------------------------------------------
module enc_round_ctrl
    import enc_pkg::*;
#(
    parameter int ROUNDS = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              abort_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic [DATA_W-1:0] key_in_i,
    input  logic              decrypt_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              busy_o,
    output logic [3:0]        round_idx_o
);

    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);
    // Decrypt starts from the last encrypt key and walks backwards.
    localparam logic [2:0] DEC_ROT  = 3'((ROUNDS - 1) % 8);

    enc_state_e        state_q, state_d;
    logic [DATA_W-1:0] blk_q,   blk_d;
    logic [DATA_W-1:0] key_q,   key_d;
    logic              dec_q,   dec_d;
    logic [3:0]        rnd_q,   rnd_d;
    logic [DATA_W-1:0] dout_q,  dout_d;
    logic [DATA_W-1:0] blk_nxt;
    logic              last_rnd;

    assign last_rnd = (rnd_q == LAST_RND);

    enc_round u_round (
        .state_i (blk_q),
        .key_i   (key_q),
        .last_i  (last_rnd),
        .state_o (blk_nxt)
    );

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        key_d   = key_q;
        dec_d   = dec_q;
        rnd_d   = rnd_q;
        dout_d  = dout_q;
        if (abort_i) begin
            state_d = IDLE;
            rnd_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_d = RUN;
                        blk_d   = data_in_i;
                        key_d   = decrypt_i ? rotl8(key_in_i, DEC_ROT) : key_in_i;
                        dec_d   = decrypt_i;
                        rnd_d   = '0;
                    end
                end
                RUN: begin
                    blk_d = blk_nxt;
                    key_d = dec_q ? rotr8(key_q, 3'd1) : rotl8(key_q, 3'd1);
                    if (last_rnd) begin
                        state_d = DONE;
                        dout_d  = blk_nxt;
                        rnd_d   = '0;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rnd_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            blk_q   <= '0;
            key_q   <= '0;
            dec_q   <= 1'b0;
            rnd_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
            rnd_q   <= rnd_d;
            dout_q  <= dout_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q == RUN);
    assign out_valid_o = (state_q == DONE);
    assign round_idx_o = (state_q == RUN) ? rnd_q : 4'd0;
    assign data_out_o  = dout_q;

endmodule

// File: tb/tb_enc_round_ctrl.sv
module tb_enc_round_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // ROUNDS=4 instance
    logic       abort = 0, in_valid = 0, decrypt = 0, out_ready = 0;
    logic [7:0] data_in = 0, key_in = 0;
    logic       in_ready, out_valid, busy;
    logic [7:0] data_out;
    logic [3:0] round_idx;

    // ROUNDS=1 instance
    logic       r1_abort = 0, r1_in_valid = 0, r1_decrypt = 0, r1_out_ready = 0;
    logic [7:0] r1_data_in = 0, r1_key_in = 0;
    logic       r1_in_ready, r1_out_valid, r1_busy;
    logic [7:0] r1_data_out;
    logic [3:0] r1_round_idx;

    int n_cmp = 0;
    int n_bad = 0;

    enc_round_ctrl #(.ROUNDS(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .abort_i(abort),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .data_in_i(data_in), .key_in_i(key_in), .decrypt_i(decrypt),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .data_out_o(data_out), .busy_o(busy), .round_idx_o(round_idx)
    );

    enc_round_ctrl #(.ROUNDS(1)) u_dut_r1 (
        .clk_i(clk), .rst_ni(rst_n), .abort_i(r1_abort),
        .in_valid_i(r1_in_valid), .in_ready_o(r1_in_ready),
        .data_in_i(r1_data_in), .key_in_i(r1_key_in), .decrypt_i(r1_decrypt),
        .out_valid_o(r1_out_valid), .out_ready_i(r1_out_ready),
        .data_out_o(r1_data_out), .busy_o(r1_busy), .round_idx_o(r1_round_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-block reference: Feistel over ints, decrypt = encrypt keys reversed.
    function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] k,
                                         input logic dec, input int r);
        int h, l, kv, s, kr, e, x, f, t;
        h  = int'(d) >> 4;
        l  = int'(d) & 15;
        kv = int'(k);
        for (int i = 0; i < r; i++) begin
            s  = dec ? ((r - 1 - i) % 8) : (i % 8);
            kr = ((kv << s) | (kv >> (8 - s))) & 255;
            e  = (((l >> 3) & 1) << 7) | (((l >> 0) & 1) << 6) |
                 (((l >> 1) & 1) << 5) | (((l >> 2) & 1) << 4) |
                 (((l >> 1) & 1) << 3) | (((l >> 3) & 1) << 2) |
                 (((l >> 2) & 1) << 1) | ((l >> 0) & 1);
            x  = e ^ kr;
            f  = ((x >> 4) + (x & 15) + (((kr & 1) != 0) ? 0 : 1)) % 16;
            if (i < r - 1) begin
                t = l;
                l = h ^ f;
                h = t;
            end else begin
                h = h ^ f;
            end
        end
        return 8'((h << 4) | l);
    endfunction

    // Cycle reference for the ROUNDS=4 instance.
    int         m_st;   // 0 idle, 1 running, 2 result held
    int         m_rnd;
    logic [7:0] m_res, m_dout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= 0; m_rnd <= 0; m_res <= 8'h00; m_dout <= 8'h00;
        end else if (abort) begin
            m_st <= 0; m_rnd <= 0;
        end else if (m_st == 0) begin
            if (in_valid) begin
                m_res <= model(data_in, key_in, decrypt, 4);
                m_st  <= 1;
                m_rnd <= 0;
            end
        end else if (m_st == 1) begin
            if (m_rnd == 3) begin
                m_st   <= 2;
                m_rnd  <= 0;
                m_dout <= m_res;
            end else begin
                m_rnd <= m_rnd + 1;
            end
        end else if (out_ready) begin
            m_st <= 0;
        end
    end

    always @(negedge clk) begin
        logic [14:0] act, exp;
        if (rst_n) begin
            act = {in_ready, busy, out_valid, round_idx, data_out};
            exp = {m_st == 0, m_st == 1, m_st == 2,
                   4'((m_st == 1) ? m_rnd : 0), m_dout};
            check("cycle {rdy,busy,vld,idx,dout}", 32'(act), 32'(exp));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov();
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            tick();
        end
        check("out_valid wait", 32'(out_valid), 1);
    endtask

    task automatic do_block(input logic [7:0] d, input logic [7:0] k,
                            input logic dec, output logic [7:0] res);
        check("in_ready before send", 32'(in_ready), 1);
        in_valid = 1; data_in = d; key_in = k; decrypt = dec; out_ready = 1;
        tick();
        in_valid = 0;
        wait_ov();
        res = data_out;
        tick();
    endtask

    task automatic r1_block(input logic [7:0] d, input logic [7:0] k,
                            input logic dec, input logic [7:0] exp);
        r1_in_valid = 1; r1_data_in = d; r1_key_in = k; r1_decrypt = dec; r1_out_ready = 1;
        tick();
        r1_in_valid = 0;
        check("r1 busy after accept", 32'(r1_busy), 1);
        check("r1 out_valid after accept", 32'(r1_out_valid), 0);
        tick();
        check("r1 out_valid second edge", 32'(r1_out_valid), 1);
        check("r1 data_out", 32'(r1_data_out), 32'(exp));
        tick();
        check("r1 in_ready after transfer", 32'(r1_in_ready), 1);
    endtask

    logic [7:0] pt_tab [3] = '{8'hC9, 8'hA5, 8'hF0};
    logic [7:0] ky_tab [3] = '{8'hAC, 8'h5A, 8'hB1};

    initial begin
        logic [7:0] enc, dec_r, exp_bp;
        #12;
        check("reset in_ready", 32'(in_ready), 1);
        check("reset busy", 32'(busy), 0);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset round_idx", 32'(round_idx), 0);
        check("reset data_out", 32'(data_out), 0);
        check("r1 reset in_ready", 32'(r1_in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1;
        tick();

        // Model pins.
        check("model pin 46/93 r1", 32'(model(8'h46, 8'h93, 0, 1)), 32'h76);
        check("model pin roundtrip", 32'(model(model(8'hC9, 8'hAC, 0, 4), 8'hAC, 1, 4)), 32'hC9);

        // ROUNDS=1 directed.
        r1_block(8'h46, 8'h93, 0, 8'h76);
        r1_block(8'h76, 8'h93, 1, 8'h46);

        // ROUNDS=4 round trips.
        for (int i = 0; i < 3; i++) begin
            do_block(pt_tab[i], ky_tab[i], 0, enc);
            do_block(enc, ky_tab[i], 1, dec_r);
            check("roundtrip", 32'(dec_r), 32'(pt_tab[i]));
        end

        // Backpressure with ignored input pulse.
        exp_bp = model(8'h3C, 8'h5E, 0, 4);
        in_valid = 1; data_in = 8'h3C; key_in = 8'h5E; decrypt = 0; out_ready = 0;
        tick();
        in_valid = 0;
        wait_ov();
        for (int i = 0; i < 10; i++) begin
            check("bp data_out", 32'(data_out), 32'(exp_bp));
            check("bp out_valid", 32'(out_valid), 1);
            check("bp in_ready", 32'(in_ready), 0);
            if (i == 3) begin in_valid = 1; data_in = 8'hFF; end
            if (i == 5) in_valid = 0;
            tick();
        end
        out_ready = 1;
        tick();
        check("bp in_ready after transfer", 32'(in_ready), 1);
        check("bp out_valid after transfer", 32'(out_valid), 0);

        // Abort at round 2.
        in_valid = 1; data_in = 8'h12; key_in = 8'h34; decrypt = 0;
        tick();
        in_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (round_idx == 4'd2) break;
            tick();
        end
        check("abort reach round 2", 32'(round_idx), 2);
        abort = 1;
        tick();
        abort = 0;
        check("abort busy", 32'(busy), 0);
        check("abort in_ready", 32'(in_ready), 1);
        check("abort round_idx", 32'(round_idx), 0);
        for (int i = 0; i < 8; i++) begin
            check("abort no out_valid", 32'(out_valid), 0);
            tick();
        end
        do_block(8'h12, 8'h34, 0, enc);
        check("post-abort result", 32'(enc), 32'(model(8'h12, 8'h34, 0, 4)));
        do_block(enc, 8'h34, 1, dec_r);
        check("post-abort decrypt", 32'(dec_r), 32'h12);

        // Asynchronous reset mid-RUN.
        in_valid = 1; data_in = 8'h9B; key_in = 8'h27; decrypt = 0;
        tick();
        in_valid = 0;
        tick();
        #3;
        rst_n = 0;
        #1;
        check("async rst in_ready", 32'(in_ready), 1);
        check("async rst busy", 32'(busy), 0);
        check("async rst out_valid", 32'(out_valid), 0);
        check("async rst round_idx", 32'(round_idx), 0);
        check("async rst data_out", 32'(data_out), 0);
        tick();
        rst_n = 1;
        tick();
        do_block(8'h9B, 8'h27, 0, enc);
        do_block(enc, 8'h27, 1, dec_r);
        check("post-reset roundtrip", 32'(dec_r), 32'h9B);

        // Abort coincident with in_valid in IDLE.
        in_valid = 1; abort = 1; data_in = 8'h77; key_in = 8'h11;
        tick();
        in_valid = 0; abort = 0;
        check("abort+accept busy", 32'(busy), 0);
        check("abort+accept in_ready", 32'(in_ready), 1);
        tick();
        check("abort+accept busy next", 32'(busy), 0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enc_round_ctrl.md
# enc_round_ctrl

Multi-round sequencer for the 8-bit expansion/XOR/carry-select encryption round. It accepts one plaintext or ciphertext byte and an 8-bit key over a valid/ready handshake, then iterates the round function ROUNDS times as a Feistel network. It generates each round key on the fly and returns the result over a second valid/ready handshake. It sits between the byte source and sink and owns the single shared round datapath.

## Interface
- ROUNDS, 4, number of rounds applied per block; legal range 1..15.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- abort  in  1  synchronous flush to IDLE; highest priority after reset.
- in_valid  in  1  input byte/key/mode present.
- in_ready  out  1  high only in IDLE.
- data_in  in  8  plaintext (encrypt) or ciphertext (decrypt).
- key_in  in  8  user key.
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with data_in.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  sink accepts result.
- data_out  out  8  result byte; stable while out_valid is high.
- busy  out  1  high in RUN.
- round_idx  out  4  index of the round applied at the next edge; 0 outside RUN.

## Operation
- Round function f(L, K), with L = state[3:0]:
  - Expansion E[7:0] = {L3, L0, L1, L2, L1, L3, L2, L0}, MSB first.
  - X = E ^ K.
  - f = (X[7:4] + X[3:0] + (K[0] ? 0 : 1)) mod 16.
- Round update, with H = state[7:4]:
  - Non-final round: state ← {L, H ^ f}, i.e. halves swapped.
  - Final round: state ← {H ^ f, L}, no swap.
- Key schedule, encrypt: K0 = key_in; K(i+1) = K(i) rotated left by 1.
- Key schedule, decrypt: K0 = key_in rotated left by (ROUNDS−1) mod 8; K(i+1) = K(i) rotated right by 1.
  - This reverses the encrypt key order, so decrypt(encrypt(x)) = x for any ROUNDS.
- FSM, state IDLE:
  - On in_valid && in_ready, load state, K0, mode and round counter = 0, then go to RUN.
- FSM, state RUN:
  - Each edge applies one round and increments round_idx.
  - The edge that applies round ROUNDS−1 writes data_out and goes to DONE.
- FSM, state DONE:
  - Hold data_out. On out_valid && out_ready go to IDLE.
- in_valid is ignored outside IDLE; no input is queued.
- abort in any state moves to IDLE at the next edge and clears out_valid, busy and round_idx. data_out keeps its last value. An abort coinciding with an accept or an output transfer wins, and nothing is accepted.
- Reset values: state IDLE; in_ready 1; out_valid 0; busy 0; round_idx 0; data_out 0x00; internal state and key 0.
- Reset asserted mid-RUN or mid-DONE drops the block immediately; the in-flight result is lost.

## Timing
- Input accepted at edge E0.
- RUN occupies edges E1..E(ROUNDS).
- out_valid is high in the cycle after E(ROUNDS): latency is ROUNDS+1 edges from accept to result visible.
- With out_ready held high, the output transfers at E(ROUNDS+1); in_ready returns in the following cycle.
- Back-to-back throughput is one block per ROUNDS+2 cycles.
- All outputs are registered or decoded from FSM state only; there is no combinational path from in_valid, out_ready or abort to any output.

## Structure
- Shared package enc_pkg:
  - constants: data width 8, half width 4.
  - state enum: IDLE, RUN, DONE.
  - functions: rotl8, rotr8.
- Sub-module enc_round: purely combinational; takes state[7:0], key[7:0] and last; produces the next state.
- enc_round_ctrl holds the FSM, round counter, key register and handshakes.

## Test plan
- ROUNDS=1, encrypt, data_in=0x46, key_in=0x93 → data_out=0x76; out_valid rises two edges after accept.
- ROUNDS=4, encrypt 0xC9 with key 0xAC, then decrypt the result with key 0xAC → 0xC9. Repeat for 0xA5/0x5A and 0xF0/0xB1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → data_out stable, out_valid stays high, in_ready stays low. Pulse in_valid during this window → ignored.
- Assert abort in RUN at round_idx=2 → IDLE next edge, busy=0, out_valid never rises. The next accepted block produces the correct result.
- Assert reset low mid-RUN, asynchronously between edges → outputs take reset values immediately. After release, in_ready=1 and a new block completes correctly.
- abort coincident with in_valid in IDLE → no accept; busy remains 0 on the following cycle.
